// File: rtl/core_pkg.sv
// Shared core types: divider op encoding, widths and latency.
package core_pkg;

  typedef enum logic [1:0] {DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU} div_op_e;

  localparam int DIV_XLEN    = 32;
  localparam int DIV_LATENCY = DIV_XLEN + 2;

  function automatic logic div_is_signed(input div_op_e op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

  function automatic logic div_is_quot(input div_op_e op);
    return (op == DIV_DIV) || (op == DIV_DIVU);
  endfunction

endpackage

// File: rtl/core_div_if.sv
// Request/response handshake bundle between execute stage and divider.
interface core_div_if
  import core_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
);

    logic            kill;
    logic            req_valid;
    logic            req_ready;
    div_op_e         req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;

    modport master (
        output kill, req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  kill, req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_result
    );

endinterface

// File: rtl/core_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module core_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] dvd,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] dvd_next
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            ge;

    // rem < divisor always holds, so the shifted value needs one extra bit
    // but the difference never does.
    always_comb begin
        shifted  = {rem, dvd[XLEN-1]};
        ge       = shifted >= {1'b0, divisor};
        diff     = shifted[XLEN-1:0] - divisor;
        rem_next = ge ? diff : shifted[XLEN-1:0];
        dvd_next = {dvd[XLEN-2:0], ge};
    end

endmodule

// File: rtl/core_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
module core_div
  import core_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input logic       clk,
    input logic       rst,
    core_div_if.slave dif
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);

    logic [1:0]       state_q, state_d;
    div_op_e          op_q, op_d;
    logic [XLEN-1:0]  dvd_q, dvd_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic [XLEN-1:0]  step_rem, step_dvd;
    logic             sgn, a_neg, b_neg, accept;
    logic [XLEN-1:0]  a_abs, b_abs, q_fix, r_fix;

    core_div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .dvd      (dvd_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .dvd_next (step_dvd)
    );

    assign dif.req_ready   = (state_q == S_IDLE) && !dif.kill;
    assign dif.resp_valid  = (state_q == S_DONE);
    assign dif.resp_result = result_q;
    assign accept          = dif.req_valid && dif.req_ready;

    always_comb begin
        sgn   = div_is_signed(dif.req_op);
        a_neg = sgn && dif.req_a[XLEN-1];
        b_neg = sgn && dif.req_b[XLEN-1];
        a_abs = a_neg ? (~dif.req_a + 1'b1) : dif.req_a;
        b_abs = b_neg ? (~dif.req_b + 1'b1) : dif.req_b;
        q_fix = neg_q_q ? (~dvd_q + 1'b1) : dvd_q;
        r_fix = neg_r_q ? (~rem_q + 1'b1) : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = dif.req_op;
                    // Divide-by-zero outranks signed overflow; both skip iteration.
                    if (dif.req_b == '0) begin
                        result_d = div_is_quot(dif.req_op) ? '1 : dif.req_a;
                        state_d  = S_DONE;
                    end else if (sgn && dif.req_a == SMIN && dif.req_b == '1) begin
                        result_d = div_is_quot(dif.req_op) ? SMIN : '0;
                        state_d  = S_DONE;
                    end else begin
                        dvd_d   = a_abs;
                        dvs_d   = b_abs;
                        rem_d   = '0;
                        neg_q_d = a_neg ^ b_neg;
                        neg_r_d = a_neg;
                        cnt_d   = CNT_INIT;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = S_FIXUP;
            end
            S_FIXUP: begin
                result_d = div_is_quot(op_q) ? q_fix : r_fix;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (dif.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (dif.kill) state_d = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= DIV_DIV;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_core_div.sv
// Scoreboard bench for core_div: directed vectors, monitor checks result and latency.
module tb_core_div;
    import core_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic prev_v = 1'b0;
    logic [31:0] held = '0;

    core_div_if #(.XLEN(32)) dif ();

    core_div #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (dif.resp_valid && !prev_v) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_resp got=%h", dif.resp_result);
                end else begin
                    exp_t e;
                    int   lat;
                    e   = sb.pop_front();
                    lat = cyc - e.acc + 1;
                    if (dif.resp_result !== e.res) begin
                        n_fail++;
                        $display("FAIL %s result got=%h exp=%h", e.name, dif.resp_result, e.res);
                    end
                    n_tests++;
                    if (lat != e.lat) begin
                        n_fail++;
                        $display("FAIL %s latency got=%0d exp=%0d", e.name, lat, e.lat);
                    end
                end
                held = dif.resp_result;
            end else if (dif.resp_valid && prev_v) begin
                n_tests++;
                if (dif.resp_result !== held) begin
                    n_fail++;
                    $display("FAIL hold_stable got=%h exp=%h", dif.resp_result, held);
                end
            end
            prev_v = dif.resp_valid;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name, input bit push);
        int guard = 0;
        @(negedge clk);
        while (!dif.req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s req_ready_timeout got=0 exp=1", name);
        end
        dif.req_valid = 1'b1;
        dif.req_op    = op;
        dif.req_a     = a;
        dif.req_b     = b;
        @(posedge clk);
        #1;
        if (push) sb.push_back('{exp, lat, cyc, name});
        dif.req_valid = 1'b0;
        dif.req_op    = DIV_REMU;
        dif.req_a     = $urandom;
        dif.req_b     = $urandom;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((sb.size() != 0 || dif.resp_valid) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s drain_timeout pending=%0d exp=0", name, sb.size());
        end
    endtask

    initial begin
        int seen;
        dif.kill       = 1'b0;
        dif.req_valid  = 1'b0;
        dif.req_op     = DIV_DIV;
        dif.req_a      = '0;
        dif.req_b      = '0;
        dif.resp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_resp_valid", 32'(dif.resp_valid), 32'd0);
        check("rst_resp_result", dif.resp_result, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(dif.req_ready), 32'd1);

        issue(DIV_DIVU, 32'd100, 32'd7, 32'd14, DIV_LATENCY, "divu_100_7", 1'b1);
        issue(DIV_REMU, 32'd100, 32'd7, 32'd2, DIV_LATENCY, "remu_100_7", 1'b1);
        issue(DIV_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LATENCY, "div_m7_2", 1'b1);
        issue(DIV_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LATENCY, "rem_m7_2", 1'b1);
        issue(DIV_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LATENCY, "div_7_m2", 1'b1);
        issue(DIV_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, DIV_LATENCY, "rem_7_m2", 1'b1);
        issue(DIV_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by_zero", 1'b1);
        issue(DIV_REMU, 32'd5, 32'd0, 32'd5, 1, "remu_by_zero", 1'b1);
        issue(DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf", 1'b1);
        issue(DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf", 1'b1);
        issue(DIV_DIV, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1, "zero_beats_ovf", 1'b1);
        issue(DIV_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, DIV_LATENCY, "divu_no_ovf", 1'b1);
        issue(DIV_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, DIV_LATENCY, "divu_wide", 1'b1);
        issue(DIV_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, DIV_LATENCY, "remu_wide", 1'b1);
        drain("vectors");

        // Flush mid-iteration: no response, unit immediately reusable.
        issue(DIV_DIVU, 32'd1000, 32'd3, 32'd0, 0, "killed", 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        dif.kill      = 1'b1;
        dif.req_valid = 1'b1;
        #1;
        check("kill_blocks_req_ready", 32'(dif.req_ready), 32'd0);
        @(posedge clk);
        #1;
        dif.kill      = 1'b0;
        dif.req_valid = 1'b0;
        @(negedge clk);
        check("kill_req_ready_after", 32'(dif.req_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.resp_valid) seen++;
        end
        check("kill_no_resp", 32'(seen), 32'd0);
        issue(DIV_DIVU, 32'd9, 32'd3, 32'd3, DIV_LATENCY, "divu_9_3_after_kill", 1'b1);
        drain("after_kill");

        // Backpressure: result held, no new accept until after handshake.
        dif.resp_ready = 1'b0;
        issue(DIV_REMU, 32'd100, 32'd7, 32'd2, DIV_LATENCY, "remu_hold", 1'b1);
        seen = 0;
        while (!dif.resp_valid && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        repeat (5) begin
            @(negedge clk);
            check("hold_resp_valid", 32'(dif.resp_valid), 32'd1);
            check("hold_req_ready", 32'(dif.req_ready), 32'd0);
        end
        dif.resp_ready = 1'b1;
        @(negedge clk);
        check("post_hs_resp_valid", 32'(dif.resp_valid), 32'd0);
        check("post_hs_req_ready", 32'(dif.req_ready), 32'd1);
        drain("hold");

        // Async reset mid-operation clears outputs without waiting for an edge.
        issue(DIV_DIVU, 32'd77, 32'd5, 32'd0, 0, "reset_mid", 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_resp_valid", 32'(dif.resp_valid), 32'd0);
        check("async_rst_resp_result", dif.resp_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("async_rst_req_ready", 32'(dif.req_ready), 32'd1);
        issue(DIV_REMU, 32'd77, 32'd5, 32'd2, DIV_LATENCY, "remu_after_rst", 1'b1);
        drain("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
